// File: rtl/pairing_result_streamer_pkg.sv
// Shared constants and state encoding for the pairing result streamer.
// W6 is the top bit index of an F(3^6) element, so a full result is W6+1 bits.
package pairing_result_streamer_pkg;

    localparam int W6          = 1163;
    localparam int PAIR_WORD_W = 32;
    localparam int PAIR_NWORDS = 37;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/pairing_result_streamer.sv
// Captures the pairing result on a rising done and streams it LSB word first; word 0 is valid the cycle after the capture edge.
// out_ready low holds the current word; a done rise while streaming is dropped and latched in overrun.
module pairing_result_streamer
    import pairing_result_streamer_pkg::*;
#(
    parameter int DATA_W = W6 + 1,
    parameter int WORD_W = PAIR_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] c,
    input  logic              done,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              overrun
);

    localparam int         NWORDS   = (DATA_W + WORD_W - 1) / WORD_W;
    localparam int         CAP_W    = NWORDS * WORD_W;
    localparam logic [5:0] LAST_IDX = 6'(NWORDS - 1);

    state_t            state;
    logic              done_q;
    logic [CAP_W-1:0]  capture;
    logic [5:0]        index;
    logic              start;
    logic              xfer;
    logic              final_xfer;

    assign start      = done & ~done_q;
    assign xfer       = out_valid & out_ready;
    assign final_xfer = xfer & (index == LAST_IDX);

    assign out_valid = (state == SEND);
    assign busy      = out_valid;
    // capture is zero-extended to a whole number of words, so the top word is padded for free
    assign out_data  = out_valid ? capture[int'(index) * WORD_W +: WORD_W] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            capture  <= '0;
            index    <= '0;
            out_last <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done_q <= done;
            case (state)
                IDLE: begin
                    if (start) begin
                        capture  <= CAP_W'(c);
                        index    <= '0;
                        out_last <= (NWORDS == 1);
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (final_xfer) begin
                        if (start) begin
                            // back-to-back result: reload without an idle cycle
                            capture  <= CAP_W'(c);
                            index    <= '0;
                            out_last <= (NWORDS == 1);
                        end else begin
                            index    <= '0;
                            out_last <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            index    <= index + 6'd1;
                            out_last <= ((index + 6'd1) == LAST_IDX);
                        end
                        if (start) begin
                            overrun <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pairing_result_streamer.sv
// Directed bench for pairing_result_streamer: full-rate, stalled, overrun,
// back-to-back, mid-stream reset and held-done streams.
module tb_pairing_result_streamer;

    localparam int DW = 1164;
    localparam int NW = 37;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] c;
    logic          done;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          overrun;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pairing_result_streamer #(.DATA_W(DW), .WORD_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .c         (c),
        .done      (done),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Expected word k of result 'seed'; word 36 holds only 12 result bits.
    function automatic logic [31:0] gen(input int seed, input int k);
        if (k == 36) return (seed == 0) ? 32'h00000A69 : 32'h000005C3;
        if (k == 0 && seed == 0) return 32'h26850589;
        return (32'(k) * 32'h01030507) ^ ((seed == 0) ? 32'h13579BDF : 32'hDEADBEEF);
    endfunction

    function automatic logic [DW-1:0] build(input int seed);
        logic [DW-1:0] v;
        logic [31:0]   top;
        v = '0;
        for (int k = 0; k < 36; k++) v[k*32 +: 32] = gen(seed, k);
        top = gen(seed, 36);
        v[1163:1152] = top[11:0];
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int seed);
        c    = build(seed);
        done = 1'b1;
        cycle();
    endtask

    // Receive one stream. act 1: raise done (result seed2) while word act_word is shown.
    // act 2: assert reset while word act_word is shown and abandon the stream.
    task automatic drain(input int seed, input bit rnd, input bit hold,
                         input int act_word, input int act, input int seed2);
        int k = 0;
        int cyc = 0;
        bit acted = 1'b0;
        while (k < NW) begin
            if (cyc == 400) begin
                chk("stream timeout words", 32'(k), 32'(NW));
                return;
            end
            if (!hold) done = 1'b0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (act != 0 && !acted && k == act_word) begin
                acted = 1'b1;
                if (act == 1) begin
                    c         = build(seed2);
                    done      = 1'b1;
                    out_ready = 1'b1;
                end else begin
                    reset = 1'b1;
                    #1;
                    chk("async rst valid", 32'(out_valid), 32'd0);
                    chk("async rst busy", 32'(busy), 32'd0);
                    chk("async rst data", out_data, 32'd0);
                    chk("async rst last", 32'(out_last), 32'd0);
                    cycle();
                    reset = 1'b0;
                    return;
                end
            end
            chk($sformatf("r%0d w%0d valid", seed, k), 32'(out_valid), 32'd1);
            chk($sformatf("r%0d w%0d busy", seed, k), 32'(busy), 32'd1);
            chk($sformatf("r%0d w%0d data", seed, k), out_data, gen(seed, k));
            chk($sformatf("r%0d w%0d last", seed, k), 32'(out_last), 32'(k == NW - 1));
            @(posedge clk);
            if (out_ready) k++;
            #1;
            cyc++;
        end
    endtask

    initial begin
        int seen;

        reset     = 1'b1;
        c         = '0;
        done      = 1'b0;
        out_ready = 1'b0;
        repeat (2) cycle();
        chk("reset data", out_data, 32'd0);
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset last", 32'(out_last), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        cycle();

        // Full rate stream
        start(0);
        drain(0, 1'b0, 1'b0, -1, 0, 0);
        chk("full busy after", 32'(busy), 32'd0);
        chk("full valid after", 32'(out_valid), 32'd0);
        chk("full data after", out_data, 32'd0);
        chk("full last after", 32'(out_last), 32'd0);
        chk("full overrun", 32'(overrun), 32'd0);

        // Random back-pressure
        start(0);
        drain(0, 1'b1, 1'b0, -1, 0, 0);
        chk("stall busy after", 32'(busy), 32'd0);
        chk("stall overrun", 32'(overrun), 32'd0);

        // Second result mid-stream is dropped
        start(0);
        drain(0, 1'b1, 1'b0, 10, 1, 1);
        chk("drop overrun", 32'(overrun), 32'd1);
        chk("drop busy after", 32'(busy), 32'd0);
        repeat (5) cycle();
        chk("drop overrun sticky", 32'(overrun), 32'd1);
        chk("drop no restream", 32'(out_valid), 32'd0);
        reset = 1'b1;
        #1;
        chk("overrun cleared", 32'(overrun), 32'd0);
        cycle();
        reset = 1'b0;
        cycle();

        // Restart on the final transfer edge
        start(0);
        drain(0, 1'b0, 1'b0, 36, 1, 1);
        chk("b2b no gap valid", 32'(out_valid), 32'd1);
        drain(1, 1'b0, 1'b0, -1, 0, 0);
        chk("b2b overrun", 32'(overrun), 32'd0);
        chk("b2b busy after", 32'(busy), 32'd0);

        // Reset mid-stream, then nothing must be re-sent
        start(0);
        drain(0, 1'b0, 1'b0, 20, 2, 0);
        done      = 1'b0;
        out_ready = 1'b1;
        seen      = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            cycle();
        end
        chk("post reset words", 32'(seen), 32'd0);

        // done held high for 100 cycles
        c    = build(0);
        done = 1'b1;
        cycle();
        drain(0, 1'b0, 1'b1, -1, 0, 0);
        seen = 0;
        for (int i = 0; i < 62; i++) begin
            if (out_valid) seen++;
            cycle();
        end
        done = 1'b0;
        cycle();
        chk("held done extra words", 32'(seen), 32'd0);
        chk("held done overrun", 32'(overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
